// File: rtl/data_cache_pkg.sv
// Shared types and defaults for the direct-mapped write-through data cache.
package data_cache_pkg;

  localparam int DEFAULT_NBITS  = 8;
  localparam int DEFAULT_NLINES = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } cache_state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/data_cache_array.sv
// Valid/tag/data storage for the direct-mapped cache with a combinational lookup port.
module cache_array
  import data_cache_pkg::*;
#(
  parameter int NBITS  = DEFAULT_NBITS,
  parameter int NLINES = DEFAULT_NLINES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NBITS-3:0] lookup_addr,
  output logic             hit,
  output logic [NBITS-1:0] lookup_data,
  input  logic             fill_en,
  input  logic             update_en,
  input  logic [NBITS-3:0] wr_addr,
  input  logic [NBITS-1:0] wr_data
);

  localparam int IW  = $clog2(NLINES);
  localparam int TW  = NBITS - 2 - IW;
  // A cache covering the whole address space has no tag bits; keep one constant-zero bit.
  localparam int TWS = (TW > 0) ? TW : 1;

  logic [NLINES-1:0] valid;
  logic [TWS-1:0]    tags [NLINES];
  logic [NBITS-1:0]  data [NLINES];

  logic [IW-1:0]  lk_idx;
  logic [TWS-1:0] lk_tag;
  logic [IW-1:0]  wr_idx;
  logic [TWS-1:0] wr_tag;
  logic           wr_match;

  assign lk_idx = lookup_addr[IW-1:0];
  assign lk_tag = TWS'(lookup_addr >> IW);
  assign wr_idx = wr_addr[IW-1:0];
  assign wr_tag = TWS'(wr_addr >> IW);

  assign hit         = valid[lk_idx] && (tags[lk_idx] == lk_tag);
  assign lookup_data = data[lk_idx];
  assign wr_match    = update_en && valid[wr_idx] && (tags[wr_idx] == wr_tag);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data arrays keep their contents across reset; only valid is cleared.
  always_ff @(posedge clock) begin
    if (fill_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end else if (wr_match) begin
      data[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, one-word-per-line, write-through / no-write-allocate data cache.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int NBITS  = DEFAULT_NBITS,
  parameter int NLINES = DEFAULT_NLINES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [NBITS-3:0] Address,
  input  logic [NBITS-1:0] WriteData,
  output logic [NBITS-1:0] ReadData,
  output logic             Stall,
  output logic             mem_req,
  output logic             mem_we,
  output logic [NBITS-3:0] mem_addr,
  output logic [NBITS-1:0] mem_wdata,
  input  logic             mem_ready,
  input  logic [NBITS-1:0] mem_rdata,
  output logic [15:0]      hit_count,
  output logic [15:0]      miss_count,
  output cache_state_t     state
);

  // Memory handshake: mem_req rises with entry to FILL/WRITE and is held, together with
  // mem_we/mem_addr/mem_wdata, until the cycle mem_ready=1 completes it; mem_ready is
  // ignored whenever mem_req is low.

  logic [NBITS-3:0] addr_q;
  logic [NBITS-1:0] wdata_q;
  logic [NBITS-1:0] fill_q;
  logic             read_done;
  logic             hit;
  logic [NBITS-1:0] lookup_data;
  logic             fill_en;
  logic             update_en;

  assign fill_en   = (state == FILL)  && mem_ready;
  assign update_en = (state == WRITE) && mem_ready;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  cache_array #(
    .NBITS (NBITS),
    .NLINES(NLINES)
  ) u_array (
    .clock      (clock),
    .reset      (reset),
    .lookup_addr(Address),
    .hit        (hit),
    .lookup_data(lookup_data),
    .fill_en    (fill_en),
    .update_en  (update_en),
    .wr_addr    (addr_q),
    .wr_data    (fill_en ? mem_rdata : wdata_q)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      fill_q     <= '0;
      read_done  <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MemWrite) begin
            state   <= WRITE;
            addr_q  <= Address;
            wdata_q <= WriteData;
            mem_req <= 1'b1;
            mem_we  <= 1'b1;
          end else if (MemRead && !hit) begin
            state      <= FILL;
            addr_q     <= Address;
            wdata_q    <= WriteData;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            miss_count <= sat_inc(miss_count);
          end else if (MemRead) begin
            hit_count <= sat_inc(hit_count);
          end
        end
        FILL: begin
          if (mem_ready) begin
            state     <= DONE;
            fill_q    <= mem_rdata;
            read_done <= 1'b1;
            mem_req   <= 1'b0;
          end
        end
        WRITE: begin
          if (mem_ready) begin
            state     <= DONE;
            read_done <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
          end
        end
        default: begin
          // DONE: requests still held by the stalled datapath are not reissued.
          state     <= IDLE;
          read_done <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    Stall = 1'b0;
    case (state)
      IDLE:    Stall = MemWrite || (MemRead && !hit);
      FILL:    Stall = 1'b1;
      WRITE:   Stall = 1'b1;
      default: Stall = 1'b0;
    endcase
  end

  always_comb begin
    ReadData = '0;
    if ((state == IDLE) && MemRead && !MemWrite && hit) begin
      ReadData = lookup_data;
    end else if ((state == DONE) && read_done) begin
      ReadData = fill_q;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: directed vector table, reset-mid-fill sequence, then random traffic
// checked against an address-level cache/memory model.
module tb_data_cache;
  import data_cache_pkg::*;

  localparam int NB = 8;
  localparam int NL = 8;
  localparam int AW = NB - 2;

  logic          clock;
  logic          reset;
  logic          MemRead;
  logic          MemWrite;
  logic [AW-1:0] Address;
  logic [NB-1:0] WriteData;
  logic [NB-1:0] ReadData;
  logic          Stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [NB-1:0] mem_wdata;
  logic          mem_ready;
  logic [NB-1:0] mem_rdata;
  logic [15:0]   hit_count;
  logic [15:0]   miss_count;
  cache_state_t  state;

  data_cache #(.NBITS(NB), .NLINES(NL)) dut (
    .clock     (clock),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .hit_count (hit_count),
    .miss_count(miss_count),
    .state     (state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: main memory plus, per index, which address is cached.
  logic [NB-1:0] mem [64];
  bit            mvalid [NL];
  logic [AW-1:0] maddr [NL];
  int            exp_hits;
  int            exp_misses;
  logic [NB-1:0] exp_q[$];

  int n_checks;
  int n_fail;

  typedef struct {
    int            op;      // 0 load, 1 store, 2 load+store together
    logic [AW-1:0] addr;
    logic [NB-1:0] data;
    int            waits;
    bit            exp_hit;
    logic [NB-1:0] exp_rd;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit model_hit(input logic [AW-1:0] a);
    int i;
    i = int'(a) % NL;
    return mvalid[i] && (maddr[i] == a);
  endfunction

  task automatic chk_counters();
    chk("hit_count", {16'd0, hit_count}, exp_hits);
    chk("miss_count", {16'd0, miss_count}, exp_misses);
  endtask

  task automatic do_load(input logic [AW-1:0] a, input int waits, input bit exp_hit,
                         input logic [NB-1:0] exp_data);
    int stalls;
    int idx;
    stalls = 0;
    idx = int'(a) % NL;
    exp_q.push_back(exp_data);
    MemRead = 1'b1;
    MemWrite = 1'b0;
    Address = a;
    WriteData = NB'($urandom);
    @(negedge clock);
    chk("load_stall_idle", {31'd0, Stall}, {31'd0, !exp_hit});
    if (exp_hit) begin
      chk("hit_rdata", {24'd0, ReadData}, {24'd0, exp_q.pop_front()});
      chk("hit_no_req", {31'd0, mem_req}, 0);
      exp_hits++;
      @(posedge clock); #1;
    end else begin
      if (Stall) stalls++;
      exp_misses++;
      @(posedge clock); #1;
      for (int w = 0; w <= waits; w++) begin
        mem_ready = (w == waits);
        mem_rdata = (w == waits) ? mem[a] : NB'($urandom);
        Address = AW'($urandom);
        @(negedge clock);
        if (Stall) stalls++;
        chk("fill_req", {31'd0, mem_req}, 1);
        chk("fill_we", {31'd0, mem_we}, 0);
        chk("fill_addr", {26'd0, mem_addr}, {26'd0, a});
        @(posedge clock); #1;
      end
      mem_ready = 1'b0;
      Address = a;
      @(negedge clock);
      if (Stall) stalls++;
      chk("miss_stall_cycles", stalls, waits + 2);
      chk("miss_rdata", {24'd0, ReadData}, {24'd0, exp_q.pop_front()});
      chk("done_no_req", {31'd0, mem_req}, 0);
      @(posedge clock); #1;
      mvalid[idx] = 1'b1;
      maddr[idx] = a;
    end
    MemRead = 1'b0;
    chk_counters();
  endtask

  task automatic do_store(input logic [AW-1:0] a, input logic [NB-1:0] d, input int waits,
                          input bit both);
    MemWrite = 1'b1;
    MemRead = both;
    Address = a;
    WriteData = d;
    @(negedge clock);
    chk("store_stall_idle", {31'd0, Stall}, 1);
    chk("store_idle_rdata", {24'd0, ReadData}, 0);
    @(posedge clock); #1;
    for (int w = 0; w <= waits; w++) begin
      mem_ready = (w == waits);
      Address = AW'($urandom);
      WriteData = NB'($urandom);
      @(negedge clock);
      chk("write_req", {31'd0, mem_req}, 1);
      chk("write_we", {31'd0, mem_we}, 1);
      chk("write_addr", {26'd0, mem_addr}, {26'd0, a});
      chk("write_wdata", {24'd0, mem_wdata}, {24'd0, d});
      chk("write_stall", {31'd0, Stall}, 1);
      @(posedge clock); #1;
    end
    mem_ready = 1'b0;
    Address = a;
    WriteData = d;
    @(negedge clock);
    chk("wdone_stall", {31'd0, Stall}, 0);
    chk("wdone_req", {31'd0, mem_req}, 0);
    chk("wdone_rdata", {24'd0, ReadData}, 0);
    @(posedge clock); #1;
    MemWrite = 1'b0;
    MemRead = 1'b0;
    mem[a] = d;
    chk_counters();
  endtask

  task automatic do_idle(input bit stray);
    MemRead = 1'b0;
    MemWrite = 1'b0;
    mem_ready = stray;
    mem_rdata = NB'($urandom);
    @(negedge clock);
    chk("idle_stall", {31'd0, Stall}, 0);
    chk("idle_req", {31'd0, mem_req}, 0);
    chk("idle_rdata", {24'd0, ReadData}, 0);
    @(posedge clock); #1;
    mem_ready = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) mvalid[i] = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    for (int i = 0; i < 64; i++) mem[i] = NB'($urandom);
    mem[6'h05] = 8'hA5;
    mem[6'h0D] = 8'h5A;
    model_reset();

    vecs[0] = '{op: 0, addr: 6'h05, data: 8'h00, waits: 2, exp_hit: 1'b0, exp_rd: 8'hA5};
    vecs[1] = '{op: 0, addr: 6'h05, data: 8'h00, waits: 0, exp_hit: 1'b1, exp_rd: 8'hA5};
    vecs[2] = '{op: 1, addr: 6'h05, data: 8'h3C, waits: 1, exp_hit: 1'b0, exp_rd: 8'h00};
    vecs[3] = '{op: 0, addr: 6'h05, data: 8'h00, waits: 0, exp_hit: 1'b1, exp_rd: 8'h3C};
    vecs[4] = '{op: 0, addr: 6'h0D, data: 8'h00, waits: 1, exp_hit: 1'b0, exp_rd: 8'h5A};
    vecs[5] = '{op: 0, addr: 6'h05, data: 8'h00, waits: 0, exp_hit: 1'b0, exp_rd: 8'h3C};
    vecs[6] = '{op: 2, addr: 6'h05, data: 8'h77, waits: 0, exp_hit: 1'b0, exp_rd: 8'h00};
    vecs[7] = '{op: 0, addr: 6'h05, data: 8'h00, waits: 0, exp_hit: 1'b1, exp_rd: 8'h77};

    reset = 1'b1;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    Address = '0;
    WriteData = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_state", {30'd0, state}, {30'd0, IDLE});
    chk("rst_stall", {31'd0, Stall}, 0);
    chk("rst_req", {31'd0, mem_req}, 0);
    chk("rst_rdata", {24'd0, ReadData}, 0);
    chk_counters();
    @(posedge clock); #1;

    // Directed vectors
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].op == 0)
        do_load(vecs[v].addr, vecs[v].waits, vecs[v].exp_hit, vecs[v].exp_rd);
      else
        do_store(vecs[v].addr, vecs[v].data, vecs[v].waits, vecs[v].op == 2);
    end

    // Reset in the middle of a fill (index 5, different tag)
    MemRead = 1'b1;
    Address = 6'h15;
    @(posedge clock); #1;
    @(negedge clock);
    chk("prefill_req", {31'd0, mem_req}, 1);
    #1 reset = 1'b1;
    #1;
    chk("rst_req_drop", {31'd0, mem_req}, 0);
    chk("rst_mid_state", {30'd0, state}, {30'd0, IDLE});
    MemRead = 1'b0;
    @(posedge clock); #1 reset = 1'b0;
    model_reset();
    chk_counters();
    do_idle(1'b1);
    do_idle(1'b1);
    do_load(6'h05, 1, 1'b0, mem[6'h05]);

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      int r;
      logic [AW-1:0] a;
      int w;
      r = $urandom_range(0, 9);
      a = AW'($urandom_range(0, 31));
      w = $urandom_range(0, 3);
      if (r < 5) begin
        do_load(a, w, model_hit(a), mem[a]);
      end else if (r < 8) begin
        do_store(a, NB'($urandom), w, r == 7);
      end else begin
        do_idle($urandom_range(0, 1) == 1);
      end
    end

    chk("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter NBITS, default 8, data word width and byte-address width.
REQ-002 Parameter NLINES, default 8, number of direct-mapped lines (power of 2, at most 2^(NBITS-2)).
REQ-003 clock  in  1  single clock; all state on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 MemRead  in  1  datapath load request.
REQ-006 MemWrite  in  1  datapath store request.
REQ-007 Address  in  NBITS-2  word address from the ALU result, bits [NBITS-1:2].
REQ-008 WriteData  in  NBITS  store data from the register file.
REQ-009 ReadData  out  NBITS  load data to the datapath result mux.
REQ-010 Stall  out  1  datapath holds PC and its inputs while high.
REQ-011 mem_req  out  1  main-memory request, held until accepted.
REQ-012 mem_we  out  1  1 = write, 0 = read; valid while mem_req.
REQ-013 mem_addr  out  NBITS-2  main-memory word address.
REQ-014 mem_wdata  out  NBITS  main-memory write data.
REQ-015 mem_ready  in  1  memory completes the pending request this cycle; mem_rdata valid.
REQ-016 mem_rdata  in  NBITS  main-memory read data.
REQ-017 hit_count, miss_count  out  16 each  saturating load hit and load miss counters.

Function
REQ-018 Organisation: direct-mapped, one word per line, write-through, no-write-allocate; index = Address[log2(NLINES)-1:0], tag = remaining upper Address bits; per-line valid, tag and data.
REQ-019 FSM states: IDLE, FILL, WRITE, DONE.
- IDLE, MemWrite=1 -> WRITE; MemWrite has priority when MemRead and MemWrite are both 1.
- IDLE, MemRead=1, miss -> FILL.
- IDLE, MemRead=1, hit -> IDLE.
- FILL or WRITE, mem_ready=1 -> DONE; otherwise stay.
- DONE -> IDLE unconditionally.
REQ-020 On any transition out of IDLE, Address and WriteData are latched; mem_addr and mem_wdata are driven from the latch and stay stable while mem_req=1.
REQ-021 mem_req=1 exactly in FILL and WRITE; mem_we=1 only in WRITE.
REQ-022 Stall = (IDLE and (MemWrite or (MemRead and miss))) or FILL or WRITE; Stall=0 in DONE; Stall is combinational.
REQ-023 Read hit: ReadData = line data in the same cycle, zero added latency.
REQ-024 Read miss: in the mem_ready cycle of FILL, the line is written (valid=1, tag, mem_rdata); in DONE, ReadData = the filled word.
REQ-025 Write: in the mem_ready cycle of WRITE, a line whose tag matches the latched address is updated with the latched data; a non-matching line is left unchanged.
REQ-026 In DONE, MemRead and MemWrite are ignored, so a held request is not reissued.
REQ-027 mem_ready outside FILL and WRITE is ignored.
REQ-028 hit_count increments once per IDLE read hit; miss_count increments once per IDLE-to-FILL transition; both saturate at 16'hFFFF.
REQ-029 ReadData = 0 when no load is being returned.
REQ-030 Total read-miss latency = 1 + (memory wait cycles) + 1 (DONE) cycles of Stall-governed sequence.

Reset
REQ-031 When reset is asserted, at any time including mid-FILL or mid-WRITE: state = IDLE, all valid bits = 0, counters = 0, mem_req = 0, address and data latches = 0.
REQ-032 Line data and tag arrays are not cleared by reset.
REQ-033 A pending memory transaction is abandoned on reset, and a late mem_ready is ignored per REQ-027.

Structure
REQ-034 A shared package holds the FSM state enum (cache_state_t) and the default NBITS and NLINES constants.
REQ-035 Sub-module cache_array holds the valid, tag and data storage and produces the combinational hit signal; FSM and counters stay in data_cache.

Verification
REQ-036 Reset, then load Address=6'h05 with 2-cycle memory latency and mem_rdata=8'hA5 -> Stall high for 4 cycles, ReadData=8'hA5 in DONE, miss_count=1.
REQ-037 Repeat load of 6'h05 -> Stall=0, ReadData=8'hA5 in the same cycle, no mem_req, hit_count=1.
REQ-038 Store 8'h3C to 6'h05 -> mem_req/mem_we held until mem_ready; next load of 6'h05 hits with 8'h3C.
REQ-039 Load 6'h0D (same index, different tag) after 6'h05 -> miss and refill; a following load of 6'h05 misses.
REQ-040 MemRead and MemWrite both 1 -> a write transaction only; no FILL.
REQ-041 Reset asserted mid-FILL -> mem_req drops immediately, next load of 6'h05 misses, and a stray mem_ready is ignored.
